// File: rtl/food_placer_pkg.sv
// Grid constants, FSM state encodings and a bounds helper for the food placer.
// FOOD_SCAN_FALLBACK_EN adds the linear-scan fallback state to the encoding.
`ifndef GRID_WIDTH
`define GRID_WIDTH 16
`endif
`ifndef GRID_HEIGHT
`define GRID_HEIGHT 12
`endif
`ifndef FOOD_MAX_TRIES
`define FOOD_MAX_TRIES 16
`endif

package food_placer_pkg;
    localparam int GRID_W     = `GRID_WIDTH;
    localparam int GRID_H     = `GRID_HEIGHT;
    localparam int GRID_CELLS = GRID_W * GRID_H;
    localparam int Y_W        = $clog2(GRID_H);
    localparam int X_W        = $clog2(GRID_W);
    localparam int SCAN_W     = $clog2(GRID_CELLS + 1);

    // Encodings are shared with the controller's debug display; keep them fixed.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_QUERY     = 2'd2
`ifdef FOOD_SCAN_FALLBACK_EN
        , ST_SCAN_STEP = 2'd3
`endif
    } state_t;

    function automatic logic in_grid(input logic [Y_W-1:0] y, input logic [X_W-1:0] x);
        return (int'(y) < GRID_H) && (int'(x) < GRID_W);
    endfunction
endpackage

// File: rtl/food_placer_if.sv
// Occupancy query bus between the food placer (master) and the snake body store (slave).
interface food_placer_if;
    import food_placer_pkg::*;

    // occ_req is the valid: once raised it holds with stable occ_y/occ_x until the
    // cycle occ_ack is high (which may be the first one); occ_hit counts only then.
    logic           occ_req;
    logic [Y_W-1:0] occ_y;
    logic [X_W-1:0] occ_x;
    logic           occ_ack;
    logic           occ_hit;

    modport master (output occ_req, occ_y, occ_x, input occ_ack, occ_hit);
    modport slave  (input occ_req, occ_y, occ_x, output occ_ack, occ_hit);
endinterface

// File: rtl/food_scan_counter.sv
// Row-major wrapping cell stepper plus a visited-cell count for the linear scan.
// Only instantiated when FOOD_SCAN_FALLBACK_EN is defined.
module food_scan_counter
    import food_placer_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           step,
    input  logic [Y_W-1:0] y,
    input  logic [X_W-1:0] x,
    output logic [Y_W-1:0] next_y,
    output logic [X_W-1:0] next_x,
    output logic           active,
    output logic           done
);
    logic [SCAN_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (step) begin
            count <= count + SCAN_W'(1);
        end
    end

    assign active = (count != '0);
    assign done   = (count == SCAN_W'(GRID_CELLS));

    // An out-of-grid starting cell restarts the walk at the origin.
    always_comb begin
        next_y = y;
        next_x = x + X_W'(1);
        if (int'(y) >= GRID_H) begin
            next_y = '0;
            next_x = '0;
        end else if (int'(x) >= GRID_W - 1) begin
            next_x = '0;
            next_y = (int'(y) >= GRID_H - 1) ? '0 : y + Y_W'(1);
        end
    end
endmodule

// File: rtl/food_placer.sv
// Turns randomizer candidates into one committed food cell, retrying on occupied cells.
// FOOD_SCAN_FALLBACK_EN enables the linear scan and BoardFull after MAX_TRIES misses.
module food_placer
    import food_placer_pkg::*;
#(
    parameter int MAX_TRIES = `FOOD_MAX_TRIES
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           place_req,
    input  logic [Y_W-1:0] cand_y,
    input  logic [X_W-1:0] cand_x,
    food_placer_if.master  occ,
    output logic [Y_W-1:0] food_y,
    output logic [X_W-1:0] food_x,
    output logic           food_valid,
    output logic           busy,
    output logic           board_full,
    output state_t         dbg_state
);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    state_t           state, state_nxt;
    logic [TRY_W-1:0] tries, tries_inc;
    logic [Y_W-1:0]   cur_y, step_y;
    logic [X_W-1:0]   cur_x, step_x;
    logic             start, load_cand, try_inc, try_clear, scan_step, commit, full_pulse;
    logic             cand_ok, load_last, query_last;

    assign tries_inc  = tries + TRY_W'(1);
    assign cand_ok    = in_grid(cand_y, cand_x);
    assign load_last  = (tries_inc == TRY_W'(MAX_TRIES));
    assign query_last = (tries == TRY_W'(MAX_TRIES));

`ifdef FOOD_SCAN_FALLBACK_EN
    logic scan_active, scan_done;

    food_scan_counter u_scan (
        .clk    (clk),
        .rst    (rst),
        .clear  (start),
        .step   (scan_step),
        .y      (cur_y),
        .x      (cur_x),
        .next_y (step_y),
        .next_x (step_x),
        .active (scan_active),
        .done   (scan_done)
    );
`else
    assign step_y = cur_y;
    assign step_x = cur_x;
`endif

    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        load_cand  = 1'b0;
        try_inc    = 1'b0;
        try_clear  = 1'b0;
        scan_step  = 1'b0;
        commit     = 1'b0;
        full_pulse = 1'b0;
        case (state)
            ST_IDLE: begin
                if (place_req) begin
                    start     = 1'b1;
                    try_clear = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_cand = 1'b1;
                try_inc   = 1'b1;
                if (cand_ok) begin
                    state_nxt = ST_QUERY;
                end else if (load_last) begin
`ifdef FOOD_SCAN_FALLBACK_EN
                    state_nxt = ST_SCAN_STEP;
`else
                    try_clear = 1'b1;
`endif
                end
            end
            ST_QUERY: begin
                if (occ.occ_ack) begin
                    if (!occ.occ_hit) begin
                        commit    = 1'b1;
                        state_nxt = ST_IDLE;
                    end
`ifdef FOOD_SCAN_FALLBACK_EN
                    // Once scanning, every further hit keeps stepping until the grid is exhausted.
                    else if (scan_done) begin
                        full_pulse = 1'b1;
                        state_nxt  = ST_IDLE;
                    end else if (scan_active || query_last) begin
                        state_nxt = ST_SCAN_STEP;
                    end
`else
                    else if (query_last) begin
                        try_clear = 1'b1;
                        state_nxt = ST_LOAD;
                    end
`endif
                    else begin
                        state_nxt = ST_LOAD;
                    end
                end
            end
`ifdef FOOD_SCAN_FALLBACK_EN
            ST_SCAN_STEP: begin
                scan_step = 1'b1;
                state_nxt = ST_QUERY;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            tries      <= '0;
            cur_y      <= '0;
            cur_x      <= '0;
            food_y     <= '0;
            food_x     <= '0;
            food_valid <= 1'b0;
            board_full <= 1'b0;
        end else begin
            state      <= state_nxt;
            board_full <= full_pulse;
            if (try_clear) begin
                tries <= '0;
            end else if (try_inc) begin
                tries <= tries_inc;
            end
            if (load_cand) begin
                cur_y <= cand_y;
                cur_x <= cand_x;
            end else if (scan_step) begin
                cur_y <= step_y;
                cur_x <= step_x;
            end
            if (start) begin
                food_valid <= 1'b0;
            end
            if (commit) begin
                food_y     <= cur_y;
                food_x     <= cur_x;
                food_valid <= 1'b1;
            end
        end
    end

    assign occ.occ_req = (state == ST_QUERY);
    assign occ.occ_y   = cur_y;
    assign occ.occ_x   = cur_x;
    assign busy        = (state != ST_IDLE);
    assign dbg_state   = state;
endmodule

// File: tb/tb_food_placer.sv
// Self-checking bench for food_placer on a 16x12 grid with MAX_TRIES=4.
// Scenarios adapt to whether FOOD_SCAN_FALLBACK_EN is defined.
module tb_food_placer;
    import food_placer_pkg::*;

    localparam int MT = 4;
    localparam int QW = Y_W + X_W;
    localparam int SEQ_N = 4096;

    logic           clk = 1'b0;
    logic           rst;
    logic           place_req;
    logic [Y_W-1:0] cand_y;
    logic [X_W-1:0] cand_x;
    logic [Y_W-1:0] food_y;
    logic [X_W-1:0] food_x;
    logic           food_valid, busy, board_full;
    state_t         dbg_state;

    food_placer_if occ_bus ();

    food_placer #(.MAX_TRIES(MT)) dut (
        .clk        (clk),
        .rst        (rst),
        .place_req  (place_req),
        .cand_y     (cand_y),
        .cand_x     (cand_x),
        .occ        (occ_bus),
        .food_y     (food_y),
        .food_x     (food_x),
        .food_valid (food_valid),
        .busy       (busy),
        .board_full (board_full),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Occupancy store model: a bit map answered after ack_delay stall cycles.
    bit occ_map [0:GRID_H-1][0:GRID_W-1];
    int ack_delay = 0;
    int req_age = 0;

    always_ff @(posedge clk) begin
        if (occ_bus.occ_req && !occ_bus.occ_ack) req_age <= req_age + 1;
        else req_age <= 0;
    end

    always_comb begin
        occ_bus.occ_ack = occ_bus.occ_req && (req_age >= ack_delay);
        occ_bus.occ_hit = 1'b1;
        if (int'(occ_bus.occ_y) < GRID_H) occ_bus.occ_hit = occ_map[occ_bus.occ_y][occ_bus.occ_x];
    end

    // Candidate presented by the randomizer in each cycle after the request.
    logic [Y_W-1:0] seq_y [0:SEQ_N-1];
    logic [X_W-1:0] seq_x [0:SEQ_N-1];
    logic [QW-1:0]  exp_q [$];

    task automatic clear_map(input bit v);
        for (int y = 0; y < GRID_H; y++)
            for (int x = 0; x < GRID_W; x++) occ_map[y][x] = v;
    endtask

    task automatic fill_seq(input int y, input int x);
        for (int i = 0; i < SEQ_N; i++) begin
            seq_y[i] = Y_W'(y);
            seq_x[i] = X_W'(x);
        end
    endtask

    // Reference: walk the placement rules cycle by cycle with plain integers.
    task automatic model_place(output int t_done, output bit full, output int fy, output int fx);
        int t, tries, y, x;
        bit done;
        exp_q.delete();
        t = 1; tries = 0; done = 0; full = 0; fy = 0; fx = 0; t_done = -1; y = 0; x = 0;
        while (!done && t < 4000) begin
            y = int'(seq_y[t]);
            x = int'(seq_x[t]);
            tries++;
            t++;
            if (y < GRID_H && x < GRID_W) begin
                exp_q.push_back({Y_W'(y), X_W'(x)});
                t++;
                if (!occ_map[y][x]) begin
                    fy = y; fx = x; t_done = t; done = 1;
                end
            end
            if (!done && tries == MT) begin
`ifdef FOOD_SCAN_FALLBACK_EN
                for (int n = 0; n < GRID_CELLS && !done; n++) begin
                    if (y >= GRID_H) begin
                        y = 0; x = 0;
                    end else begin
                        x++;
                        if (x == GRID_W) begin
                            x = 0;
                            y = (y + 1) % GRID_H;
                        end
                    end
                    t++;
                    exp_q.push_back({Y_W'(y), X_W'(x)});
                    t++;
                    if (!occ_map[y][x]) begin
                        fy = y; fx = x; t_done = t; done = 1;
                    end
                end
                if (!done) begin
                    full = 1; t_done = t; done = 1;
                end
`else
                tries = 0;
`endif
            end
        end
    endtask

    // One placement from PlaceReq to completion, checked against the reference.
    task automatic run_place(input string name, output int got_done, output int n_q);
        int t_done, fy, fx, t;
        bit full, seen_full;
        logic [QW-1:0] got_q [$];
        model_place(t_done, full, fy, fx);
        @(posedge clk); #1;
        place_req = 1'b1;
        cand_y = seq_y[0];
        cand_x = seq_x[0];
        t = 0; got_done = -1; seen_full = 0;
        while (got_done < 0 && t < 5000) begin
            @(posedge clk); #1;
            t++;
            place_req = 1'b0;
            cand_y = seq_y[t % SEQ_N];
            cand_x = seq_x[t % SEQ_N];
            if (occ_bus.occ_req && occ_bus.occ_ack) got_q.push_back({occ_bus.occ_y, occ_bus.occ_x});
            if (food_valid || board_full || !busy) begin
                got_done = t;
                seen_full = board_full;
            end
        end
        n_q = got_q.size();
        checks++;
        if (got_done !== t_done) begin
            failures++;
            $display("FAIL %s done_cycle got=%0d exp=%0d", name, got_done, t_done);
        end
        checks++;
        if (seen_full !== full) begin
            failures++;
            $display("FAIL %s board_full got=%0b exp=%0b", name, seen_full, full);
        end
        checks++;
        if (food_valid !== !full) begin
            failures++;
            $display("FAIL %s food_valid got=%0b exp=%0b", name, food_valid, !full);
        end
        if (!full) begin
            checks++;
            if (food_y !== Y_W'(fy) || food_x !== X_W'(fx)) begin
                failures++;
                $display("FAIL %s food got=(%0d,%0d) exp=(%0d,%0d)", name, food_y, food_x, fy, fx);
            end
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s query_count got=%0d exp=%0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s query[%0d] got=%h exp=%h", name, i, got_q[i], exp_q[i]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || board_full !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done busy=%0b board_full=%0b exp 0/0", name, busy, board_full);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (food_y !== '0 || food_x !== '0 || food_valid !== 1'b0 || busy !== 1'b0 ||
            occ_bus.occ_req !== 1'b0 || board_full !== 1'b0 || occ_bus.occ_y !== '0 ||
            occ_bus.occ_x !== '0 || dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL %s outputs food=(%0d,%0d) fv=%0b busy=%0b req=%0b bf=%0b occ=(%0d,%0d) st=%0d exp all 0",
                     name, food_y, food_x, food_valid, busy, occ_bus.occ_req, board_full,
                     occ_bus.occ_y, occ_bus.occ_x, dbg_state);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
    endtask

    task automatic test_free_cell();
        int d, n;
        clear_map(0);
        fill_seq(5, 7);
        run_place("free_cell", d, n);
        checks++;
        if (d !== 3 || n !== 1) begin
            failures++;
            $display("FAIL free_cell timing done=%0d queries=%0d exp 3/1", d, n);
        end
    endtask

    task automatic test_two_hits();
        int d, n;
        clear_map(0);
        occ_map[1][1] = 1; occ_map[2][2] = 1;
        fill_seq(9, 3);
        seq_y[1] = 1; seq_x[1] = 1;
        seq_y[3] = 2; seq_x[3] = 2;
        run_place("two_hits", d, n);
        checks++;
        if (d !== 7 || n !== 3 || food_y !== 9 || food_x !== 3) begin
            failures++;
            $display("FAIL two_hits done=%0d queries=%0d food=(%0d,%0d) exp 7/3/(9,3)", d, n, food_y, food_x);
        end
    endtask

    task automatic test_out_of_range();
        int d, n;
        clear_map(0);
        fill_seq(4, 4);
        seq_y[1] = 13; seq_x[1] = 2;
        run_place("out_of_range", d, n);
        checks++;
        if (d !== 4 || n !== 1) begin
            failures++;
            $display("FAIL out_of_range done=%0d queries=%0d exp 4/1", d, n);
        end
    endtask

    task automatic test_max_tries();
        int d, n;
        clear_map(0);
`ifdef FOOD_SCAN_FALLBACK_EN
        occ_map[1][1] = 1; occ_map[2][2] = 1; occ_map[3][3] = 1;
        occ_map[11][15] = 1; occ_map[0][0] = 1; occ_map[0][1] = 1;
        fill_seq(1, 1);
        seq_y[3] = 2;  seq_x[3] = 2;
        seq_y[5] = 3;  seq_x[5] = 3;
        seq_y[7] = 11; seq_x[7] = 15;
        run_place("scan_fallback", d, n);
        checks++;
        if (d !== 15 || n !== 7 || food_y !== 0 || food_x !== 2) begin
            failures++;
            $display("FAIL scan_fallback done=%0d queries=%0d food=(%0d,%0d) exp 15/7/(0,2)", d, n, food_y, food_x);
        end
`else
        occ_map[1][1] = 1;
        fill_seq(1, 1);
        seq_y[21] = 6; seq_x[21] = 6;
        run_place("retry_loop", d, n);
        checks++;
        if (d !== 23 || n !== 11 || food_y !== 6 || food_x !== 6) begin
            failures++;
            $display("FAIL retry_loop done=%0d queries=%0d food=(%0d,%0d) exp 23/11/(6,6)", d, n, food_y, food_x);
        end
`endif
    endtask

`ifdef FOOD_SCAN_FALLBACK_EN
    task automatic test_board_full();
        int d, n;
        clear_map(1);
        fill_seq(3, 4);
        run_place("board_full", d, n);
        checks++;
        if (d !== 393 || n !== MT + GRID_CELLS) begin
            failures++;
            $display("FAIL board_full_totals done=%0d queries=%0d exp 393/%0d", d, n, MT + GRID_CELLS);
        end
    endtask
`endif

    task automatic test_stall();
        clear_map(0);
        ack_delay = 3;
        @(posedge clk); #1;
        place_req = 1'b1;
        cand_y = Y_W'($urandom_range(0, GRID_H - 1));
        cand_x = X_W'($urandom_range(0, GRID_W - 1));
        for (int t = 1; t <= 8; t++) begin
            @(posedge clk); #1;
            place_req = (t == 3);
            if (t == 1) begin
                cand_y = 4; cand_x = 6;
            end else begin
                cand_y = Y_W'($urandom_range(0, GRID_H - 1));
                cand_x = X_W'((6 + $urandom_range(1, GRID_W - 1)) % GRID_W);
            end
            if (t >= 2 && t <= 5) begin
                checks++;
                if (occ_bus.occ_req !== 1'b1 || occ_bus.occ_y !== 4 || occ_bus.occ_x !== 6 ||
                    occ_bus.occ_ack !== (t == 5)) begin
                    failures++;
                    $display("FAIL stall_hold c%0d req=%0b ack=%0b occ=(%0d,%0d) exp 1/%0b/(4,6)",
                             t, occ_bus.occ_req, occ_bus.occ_ack, occ_bus.occ_y, occ_bus.occ_x, t == 5);
                end
            end
            if (t == 6) begin
                checks++;
                if (food_valid !== 1'b1 || food_y !== 4 || food_x !== 6 || occ_bus.occ_req !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_commit fv=%0b food=(%0d,%0d) req=%0b exp 1/(4,6)/0",
                             food_valid, food_y, food_x, occ_bus.occ_req);
                end
            end
            if (t >= 6) begin
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_ignored_req c%0d busy=%0b exp 0", t, busy);
                end
            end
        end
        ack_delay = 0;
    endtask

    task automatic test_reset_mid_query();
        int d, n;
        clear_map(0);
        ack_delay = 1;
        @(posedge clk); #1;
        place_req = 1'b1; cand_y = 2; cand_x = 3;
        @(posedge clk); #1;
        place_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (occ_bus.occ_req !== 1'b1 || occ_bus.occ_ack !== 1'b1) begin
            failures++;
            $display("FAIL mid_query_setup req=%0b ack=%0b exp 1/1", occ_bus.occ_req, occ_bus.occ_ack);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("reset_mid_query");
        rst = 1'b0;
        ack_delay = 0;
        fill_seq(2, 3);
        run_place("restart", d, n);
        checks++;
        if (d !== 3) begin
            failures++;
            $display("FAIL restart done=%0d exp 3", d);
        end
    endtask

    task automatic test_random();
        int d, n, dens;
        for (int it = 0; it < 25; it++) begin
            dens = $urandom_range(0, 90);
            for (int y = 0; y < GRID_H; y++)
                for (int x = 0; x < GRID_W; x++)
                    occ_map[y][x] = ($urandom_range(0, 99) < dens);
            occ_map[$urandom_range(0, GRID_H - 1)][$urandom_range(0, GRID_W - 1)] = 0;
            for (int i = 0; i < SEQ_N; i++) begin
                seq_y[i] = Y_W'($urandom_range(0, 13));
                seq_x[i] = X_W'($urandom_range(0, GRID_W - 1));
            end
            run_place("random", d, n);
        end
    endtask

    initial begin
        rst = 1'b1;
        place_req = 1'b0;
        cand_y = '0;
        cand_x = '0;
        clear_map(0);
        test_reset();
        test_free_cell();
        test_two_hits();
        test_out_of_range();
        test_max_tries();
`ifdef FOOD_SCAN_FALLBACK_EN
        test_board_full();
`endif
        test_stall();
        test_reset_mid_query();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
